// File: rtl/four_bit_multiplier.sv
// ---------------------------------------------------------------------------
// four_bit_multiplier
//   Sequential 4x4 unsigned shift-add multiplier. An accepted start latches
//   the operands and then one partial product is added per clock, so the
//   8-bit product appears exactly four clocks after the accepting edge,
//   together with a one-cycle done pulse. The product register holds its
//   value until the next completed operation (or reset).
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset (priority over everything)
//   start  in   1  operation request, accepted only while idle
//   a      in   4  multiplicand, sampled at the accepting edge only
//   b      in   4  multiplier, sampled at the accepting edge only
//   y      out  8  registered product, held until the next done
//   busy   out  1  high while an operation is in progress
//   done   out  1  one-cycle pulse coincident with a new y
// ---------------------------------------------------------------------------
module four_bit_multiplier #(
  parameter int N_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic [2*N_BITS-1:0]   y,
  output logic                  busy,
  output logic                  done
);

  localparam int P_BITS = 2 * N_BITS;
  localparam int CNT_W  = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q,  state_d;
  logic [P_BITS-1:0]   mcand_q,  mcand_d;
  logic [N_BITS-1:0]   mplier_q, mplier_d;
  logic [P_BITS-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [P_BITS-1:0]   y_q,      y_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;

  logic [P_BITS-1:0]   addend_s;
  logic [P_BITS-1:0]   sum_s;

  // Partial-product add for the current RUN step; the largest product
  // (15*15) fits in 8 bits, so no carry out is needed.
  always_comb begin
    if (mplier_q[0]) begin
      addend_s = mcand_q;
    end else begin
      addend_s = {P_BITS{1'b0}};
    end
    sum_s = acc_q + addend_s;
  end

  // Next-state logic for the controller and datapath registers.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{(P_BITS-N_BITS){1'b0}}, a};
          mplier_d = b;
          acc_d    = {P_BITS{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end else begin
          busy_d   = 1'b0;
        end
      end
      S_RUN: begin
        acc_d    = sum_s;
        mcand_d  = {mcand_q[P_BITS-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[N_BITS-1:1]};
        cnt_d    = cnt_q + 3'd1;
        // cnt_q counts completed steps, so value 3 marks the 4th RUN edge.
        if (cnt_q == 3'(N_BITS - 1)) begin
          y_d     = sum_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any
  // operation in flight without producing a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= {P_BITS{1'b0}};
      mplier_q <= {N_BITS{1'b0}};
      acc_q    <= {P_BITS{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      y_q      <= {P_BITS{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_four_bit_multiplier.sv
// ---------------------------------------------------------------------------
// tb_four_bit_multiplier
//   Scenario tasks drive the multiplier and compare against a reference
//   product computed with plain integer multiplication. Inputs change and
//   outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_four_bit_multiplier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] y;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_bad;
  logic [7:0] model_y;   // last product the reference says y must hold

  four_bit_multiplier #(.N_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .y     (y),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_product(input int x, input int z);
    int p;
    p = x * z;
    return p[7:0];
  endfunction

  // One full operation: start pulse, four RUN cycles, one trailing cycle.
  task automatic do_mult(input logic [3:0] av, input logic [3:0] bv, input string tag);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || y !== model_y) begin
      n_bad++;
      $display("FAIL %s accept: busy=%b done=%b y=%02h, expected busy=1 done=0 y=%02h", tag, busy, done, y, model_y);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || y !== model_y) begin
          n_bad++;
          $display("FAIL %s run%0d: busy=%b done=%b y=%02h, expected busy=1 done=0 y=%02h", tag, k, busy, done, y, model_y);
        end
      end else begin
        model_y = ref_product(int'(av), int'(bv));
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b1 || y !== model_y) begin
          n_bad++;
          $display("FAIL %s done: busy=%b done=%b y=%02h, expected busy=0 done=1 y=%02h", tag, busy, done, y, model_y);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== model_y) begin
      n_bad++;
      $display("FAIL %s after: busy=%b done=%b y=%02h, expected busy=0 done=0 y=%02h", tag, busy, done, y, model_y);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    @(negedge clk);
    @(negedge clk);
    model_y = 8'h00;
    n_cmp++;
    if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: y=%02h busy=%b done=%b, expected y=00 busy=0 done=0", y, busy, done);
    end
    rst_n = 1'b1;
    a = 4'd5; b = 4'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_hold%0d: y=%02h busy=%b done=%b, expected y=00 busy=0 done=0", k, y, busy, done);
      end
    end
  endtask

  task automatic test_directed();
    do_mult(4'd15, 4'd15, "mul_15x15");
    do_mult(4'd13, 4'd11, "mul_13x11");
    do_mult(4'd0,  4'd9,  "mul_0x9");
    do_mult(4'd1,  4'd1,  "mul_1x1");
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    start = 1'b1; a = 4'd3; b = 4'd5;
    @(negedge clk);                      // E0 accepted
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    model_y = ref_product(3, 5);
    n_cmp++;
    if (done !== 1'b1 || y !== model_y) begin
      n_bad++;
      $display("FAIL b2b_first: done=%b y=%02h, expected done=1 y=%02h", done, y, model_y);
    end
    a = 4'd7; b = 4'd6;                  // start still high through done
    @(negedge clk);                      // second operation accepted here
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1 || y !== model_y) begin
      n_bad++;
      $display("FAIL b2b_accept: done=%b busy=%b y=%02h, expected done=0 busy=1 y=%02h", done, busy, y, model_y);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    @(negedge clk);
    model_y = ref_product(7, 6);
    n_cmp++;
    if (done !== 1'b1 || y !== model_y) begin
      n_bad++;
      $display("FAIL b2b_second: done=%b y=%02h, expected done=1 y=%02h", done, y, model_y);
    end
    @(negedge clk);
    if (done === 1'b1) pulses++;
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL b2b_pulse_width: extra done cycles=%0d, expected 1 (first done only counted)", pulses);
    end
  endtask

  task automatic test_ignore_busy();
    int pulses;
    pulses = 0;
    start = 1'b1; a = 4'd2; b = 4'd3;
    @(negedge clk);                      // E0
    start = 1'b0;
    @(negedge clk);                      // E1
    start = 1'b1; a = 4'd9; b = 4'd9;
    @(negedge clk);                      // E2 with start ignored
    start = 1'b0;
    @(negedge clk);                      // E3
    @(negedge clk);                      // E4
    model_y = ref_product(2, 3);
    n_cmp++;
    if (done !== 1'b1 || y !== model_y) begin
      n_bad++;
      $display("FAIL ignore_busy_done: done=%b y=%02h, expected done=1 y=%02h", done, y, model_y);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || y !== model_y) begin
      n_bad++;
      $display("FAIL ignore_busy_quiet: active cycles=%0d y=%02h, expected 0 and y=%02h", pulses, y, model_y);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    pulses = 0;
    start = 1'b1; a = 4'd12; b = 4'd12;
    @(negedge clk);                      // E0
    start = 1'b0;
    @(negedge clk);                      // E1
    rst_n = 1'b0;
    @(negedge clk);                      // E2 under reset
    rst_n = 1'b1;
    model_y = 8'h00;
    n_cmp++;
    if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: y=%02h busy=%b done=%b, expected y=00 busy=0 done=0", y, busy, done);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || y !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: active cycles=%0d y=%02h, expected 0 and y=00", pulses, y);
    end
  endtask

  task automatic test_random();
    logic [3:0] ra;
    logic [3:0] rb;
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      do_mult(ra, rb, $sformatf("rand%0d_%0dx%0d", i, ra, rb));
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || y !== model_y) begin
          n_bad++;
          $display("FAIL rand%0d_idle%0d: done=%b busy=%b y=%02h, expected done=0 busy=0 y=%02h", i, k, done, busy, y, model_y);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_y = 8'h00;
    rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
